apb_completer: RTL and testbench

APB_COMPLETER -- requirements
Module: apb_completer

---
 rtl/apb_completer.sv | 173 +++++++++++++++++
 tb/tb_apb_completer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_completer.sv
// APB completer with a small register file, optional wait states and
// per-signal parity protection (CHK = NOT of the XOR of the covered bits).
// Register 0 is a read-only ID; every other register is byte-writable.
module apb_completer #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter int                    WAIT_STATES = 0,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic                             PCLK,
  input  logic                             PRESETn,
  input  logic [ADDR_WIDTH-1:0]            PADDR,
  input  logic [2:0]                       PPROT,
  input  logic                             PSEL,
  input  logic                             PENABLE,
  input  logic                             PWRITE,
  input  logic [DATA_WIDTH-1:0]            PWDATA,
  input  logic [DATA_WIDTH/8-1:0]          PSTRB,
  input  logic                             PWAKEUP,
  output logic                             PREADY,
  output logic [DATA_WIDTH-1:0]            PRDATA,
  output logic                             PSLVERR,
  input  logic [(ADDR_WIDTH+7)/8-1:0]      PADDRCHK,
  input  logic                             PCTRLCHK,
  input  logic                             PSELCHK,
  input  logic                             PENABLECHK,
  input  logic                             PWAKEUPCHK,
  input  logic [DATA_WIDTH/8-1:0]          PWDATACHK,
  input  logic                             PSTRBCHK,
  output logic                             PREADYCHK,
  output logic                             PSLVERRCHK,
  output logic [DATA_WIDTH/8-1:0]          PRDATACHK,
  output logic [7:0]                       err_count
);

  localparam int P  = DATA_WIDTH / 8;
  localparam int A  = (ADDR_WIDTH + 7) / 8;
  localparam int LP = $clog2(P);
  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic                    perr_q, perr_d;
  logic [7:0]              err_count_q, err_count_d;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];

  logic [A*8-1:0]          paddr_pad;
  logic                    in_par_err;
  logic [ADDR_WIDTH-1:0]   idx;
  logic                    addr_err;
  logic                    xfer_err;
  logic [DATA_WIDTH-1:0]   rd_val;

  assign paddr_pad = (A*8)'(PADDR);

  // Any input parity mismatch on the bus in the current cycle
  always_comb begin
    in_par_err = 1'b0;
    for (int i = 0; i < A; i++) begin
      if (PADDRCHK[i] != ~^paddr_pad[8*i +: 8]) in_par_err = 1'b1;
    end
    for (int i = 0; i < P; i++) begin
      if (PWDATACHK[i] != ~^PWDATA[8*i +: 8]) in_par_err = 1'b1;
    end
    if (PCTRLCHK   != ~^{PPROT, PWRITE}) in_par_err = 1'b1;
    if (PSELCHK    != ~PSEL)             in_par_err = 1'b1;
    if (PENABLECHK != ~PENABLE)          in_par_err = 1'b1;
    if (PWAKEUPCHK != ~PWAKEUP)          in_par_err = 1'b1;
    if (PSTRBCHK   != ~^PSTRB)           in_par_err = 1'b1;
  end

  // Decode the captured address: alignment, range, ID write, and read mux
  always_comb begin
    idx      = addr_q >> LP;
    addr_err = ((addr_q & ADDR_WIDTH'(P - 1)) != '0) ||
               (idx >= ADDR_WIDTH'(NUM_REGS)) ||
               (write_q && (idx == '0));
    rd_val   = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (idx == ADDR_WIDTH'(i)) rd_val = regs_q[i];
    end
  end

  // Error seen so far plus anything wrong on the bus this cycle
  assign xfer_err = addr_err || perr_q || in_par_err;

  // Next-state logic: setup capture, wait countdown, abort and completion
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    write_d     = write_q;
    perr_d      = perr_q;
    err_count_d = err_count_q;
    regs_d      = regs_q;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d = ACCESS;
          cnt_d   = CW'(WAIT_STATES);
          addr_d  = PADDR;
          write_d = PWRITE;
          perr_d  = in_par_err;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          perr_d = perr_q || in_par_err;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else if (PENABLE) begin
            state_d = IDLE;
            if (xfer_err) begin
              if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
            end else if (write_q) begin
              for (int i = 1; i < NUM_REGS; i++) begin
                if (idx == ADDR_WIDTH'(i)) begin
                  for (int b = 0; b < P; b++) begin
                    if (PSTRB[b]) regs_d[i][8*b +: 8] = PWDATA[8*b +: 8];
                  end
                end
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and storage registers, cleared asynchronously by reset
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      perr_q      <= 1'b0;
      err_count_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      perr_q      <= perr_d;
      err_count_q <= err_count_d;
      regs_q      <= regs_d;
    end
  end

  // Response outputs and their parity
  always_comb begin
    PREADY    = (state_q == ACCESS) && (cnt_q == '0);
    PSLVERR   = PREADY && xfer_err;
    PRDATA    = (PREADY && !xfer_err && !write_q) ? rd_val : '0;
    PREADYCHK  = ~PREADY;
    PSLVERRCHK = ~PSLVERR;
    for (int i = 0; i < P; i++) PRDATACHK[i] = ~^PRDATA[8*i +: 8];
  end

  assign err_count = err_count_q;

endmodule

// File: tb/tb_apb_completer.sv
// Randomized bench for apb_completer: two instances (0 and 3 wait states)
// share one APB bus with separate selects, checked against a register-map
// model kept in plain arrays.
module tb_apb_completer;

  localparam logic [31:0] ID = 32'hA9B0_0001;
  localparam int WS0 = 0;
  localparam int WS1 = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] paddr;
  logic [2:0]  pprot;
  logic [1:0]  psel;
  logic        penable, pwrite, pwakeup;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [1:0]  paddrchk;
  logic        pctrlchk, penablechk, pwakeupchk, pstrbchk;
  logic [1:0]  pselchk;
  logic [3:0]  pwdatachk;

  logic        pready [2];
  logic        pslverr [2];
  logic [31:0] prdata [2];
  logic        preadychk [2];
  logic        pslverrchk [2];
  logic [3:0]  prdatachk [2];
  logic [7:0]  errCountOut [2];

  logic [31:0] model [2][16];
  int          errCnt [2];
  int          compared = 0;
  int          mismatched = 0;

  always #5 clk = ~clk;

  apb_completer #(.WAIT_STATES(WS0)) dut0 (
    .PCLK(clk), .PRESETn(rst_n), .PADDR(paddr), .PPROT(pprot), .PSEL(psel[0]),
    .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
    .PWAKEUP(pwakeup), .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0]),
    .PADDRCHK(paddrchk), .PCTRLCHK(pctrlchk), .PSELCHK(pselchk[0]),
    .PENABLECHK(penablechk), .PWAKEUPCHK(pwakeupchk), .PWDATACHK(pwdatachk),
    .PSTRBCHK(pstrbchk), .PREADYCHK(preadychk[0]), .PSLVERRCHK(pslverrchk[0]),
    .PRDATACHK(prdatachk[0]), .err_count(errCountOut[0]));

  apb_completer #(.WAIT_STATES(WS1)) dut1 (
    .PCLK(clk), .PRESETn(rst_n), .PADDR(paddr), .PPROT(pprot), .PSEL(psel[1]),
    .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata), .PSTRB(pstrb),
    .PWAKEUP(pwakeup), .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1]),
    .PADDRCHK(paddrchk), .PCTRLCHK(pctrlchk), .PSELCHK(pselchk[1]),
    .PENABLECHK(penablechk), .PWAKEUPCHK(pwakeupchk), .PWDATACHK(pwdatachk),
    .PSTRBCHK(pstrbchk), .PREADYCHK(preadychk[1]), .PSLVERRCHK(pslverrchk[1]),
    .PRDATACHK(prdatachk[1]), .err_count(errCountOut[1]));

  // One comparison: count it and report a mismatch
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] byteParity(input logic [31:0] v);
    return {~^v[31:24], ~^v[23:16], ~^v[15:8], ~^v[7:0]};
  endfunction

  // Drive correct parity for every input, optionally corrupting PWDATACHK bit 0
  task automatic driveParity(input bit flip);
    paddrchk   = {~^paddr[15:8], ~^paddr[7:0]};
    pctrlchk   = ~^{pprot, pwrite};
    pselchk    = ~psel;
    penablechk = ~penable;
    pwakeupchk = ~pwakeup;
    pwdatachk  = byteParity(pwdata) ^ {3'b000, flip};
    pstrbchk   = ~^pstrb;
  endtask

  task automatic resetModel();
    for (int d = 0; d < 2; d++) begin
      errCnt[d] = 0;
      for (int i = 0; i < 16; i++) model[d][i] = '0;
    end
  endtask

  // Full setup/access transfer on instance d, checked against the model
  task automatic applyStimulus(input int d, input logic [15:0] addr, input bit wr,
                               input logic [31:0] wd, input logic [3:0] st, input bit flip);
    int          idx;
    bit          err;
    logic [31:0] expRd;
    int          waits;
    idx   = int'(addr) / 4;
    err   = (addr % 4 != 0) || (idx >= 16) || (wr && idx == 0) || flip;
    expRd = '0;
    if (!err && !wr) expRd = (idx == 0) ? ID : model[d][idx];

    @(negedge clk);
    paddr = addr; pwrite = wr; pwdata = wd; pstrb = st;
    pprot = 3'($urandom); pwakeup = 1'($urandom);
    psel = '0; psel[d] = 1'b1; penable = 1'b0;
    driveParity(flip);
    @(negedge clk);
    penable = 1'b1;
    driveParity(flip);
    #1;
    waits = 0;
    while (!pready[d] && waits < 20) begin
      @(negedge clk);
      #1;
      waits++;
    end
    checkOutput("latency", 32'(waits), 32'((d == 0) ? WS0 : WS1));
    checkOutput("pslverr", {31'b0, pslverr[d]}, {31'b0, err});
    checkOutput("prdata", prdata[d], expRd);
    checkOutput("prdatachk", {28'b0, prdatachk[d]}, {28'b0, byteParity(expRd)});
    checkOutput("preadychk", {31'b0, preadychk[d]}, 32'd0);
    checkOutput("pslverrchk", {31'b0, pslverrchk[d]}, {31'b0, ~err});

    if (err) begin
      if (errCnt[d] < 255) errCnt[d]++;
    end else if (wr) begin
      for (int b = 0; b < 4; b++)
        if (st[b]) model[d][idx][8*b +: 8] = wd[8*b +: 8];
    end

    @(negedge clk);
    psel = '0; penable = 1'b0;
    driveParity(1'b0);
    #1;
    checkOutput("err_count", {24'b0, errCountOut[d]}, 32'(errCnt[d]));
    checkOutput("pready_idle", {31'b0, pready[d]}, 32'd0);
  endtask

  // Select drops during the wait states: no commit, no error
  task automatic abortTransfer(input logic [15:0] addr, input logic [31:0] wd);
    @(negedge clk);
    paddr = addr; pwrite = 1'b1; pwdata = wd; pstrb = 4'hF;
    psel = 2'b10; penable = 1'b0;
    driveParity(1'b0);
    @(negedge clk);
    penable = 1'b1;
    driveParity(1'b0);
    @(negedge clk);
    psel = '0; penable = 1'b0;
    driveParity(1'b0);
    @(negedge clk);
    #1;
    checkOutput("abort_pready", {31'b0, pready[1]}, 32'd0);
    checkOutput("abort_errcnt", {24'b0, errCountOut[1]}, 32'(errCnt[1]));
  endtask

  task automatic checkResetOutputs(input int d);
    checkOutput("rst_pready", {31'b0, pready[d]}, 32'd0);
    checkOutput("rst_pslverr", {31'b0, pslverr[d]}, 32'd0);
    checkOutput("rst_prdata", prdata[d], 32'd0);
    checkOutput("rst_preadychk", {31'b0, preadychk[d]}, 32'd1);
    checkOutput("rst_pslverrchk", {31'b0, pslverrchk[d]}, 32'd1);
    checkOutput("rst_prdatachk", {28'b0, prdatachk[d]}, 32'hF);
    checkOutput("rst_errcnt", {24'b0, errCountOut[d]}, 32'd0);
  endtask

  initial begin
    int          d;
    logic [15:0] a;
    bit          wr;
    bit          flip;
    rst_n = 1'b0;
    paddr = '0; pprot = '0; psel = '0; penable = 1'b0; pwrite = 1'b0;
    pwdata = '0; pstrb = '0; pwakeup = 1'b0;
    driveParity(1'b0);
    resetModel();
    repeat (3) @(negedge clk);
    #1;
    checkResetOutputs(0);
    checkResetOutputs(1);
    @(negedge clk);
    rst_n = 1'b1;

    // Full write then read back, no wait states
    applyStimulus(0, 16'h0004, 1'b1, 32'h1234_5678, 4'hF, 1'b0);
    applyStimulus(0, 16'h0004, 1'b0, 32'h0, 4'h0, 1'b0);
    // Partial strobes over zero contents
    applyStimulus(0, 16'h0008, 1'b1, 32'hAABB_CCDD, 4'b0101, 1'b0);
    applyStimulus(0, 16'h0008, 1'b0, 32'h0, 4'h0, 1'b0);
    // ID read with three wait states
    applyStimulus(1, 16'h0000, 1'b0, 32'h0, 4'h0, 1'b0);
    // ID write, misaligned and out-of-range reads, ID intact afterwards
    applyStimulus(0, 16'h0000, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0);
    applyStimulus(0, 16'h0041, 1'b0, 32'h0, 4'h0, 1'b0);
    applyStimulus(0, 16'h0040, 1'b0, 32'h0, 4'h0, 1'b0);
    applyStimulus(0, 16'h0000, 1'b0, 32'h0, 4'h0, 1'b0);
    // Corrupted write-data parity leaves the target untouched
    applyStimulus(1, 16'h0010, 1'b1, 32'hCAFE_F00D, 4'hF, 1'b1);
    applyStimulus(1, 16'h0010, 1'b0, 32'h0, 4'h0, 1'b0);
    // Aborted write leaves the target untouched
    abortTransfer(16'h0014, 32'h5555_AAAA);
    applyStimulus(1, 16'h0014, 1'b0, 32'h0, 4'h0, 1'b0);

    // Randomized traffic on both instances
    for (int n = 0; n < 60; n++) begin
      d    = int'($urandom_range(0, 1));
      a    = 16'($urandom_range(0, 17) * 4);
      if ($urandom_range(0, 9) == 0) a = a + 16'($urandom_range(1, 3));
      wr   = 1'($urandom);
      flip = ($urandom_range(0, 7) == 0);
      applyStimulus(d, a, wr, $urandom, 4'($urandom), flip);
    end

    // Reset asserted mid-write during the wait states
    applyStimulus(1, 16'h0018, 1'b1, 32'h0F0F_0F0F, 4'hF, 1'b0);
    @(negedge clk);
    paddr = 16'h0018; pwrite = 1'b1; pwdata = 32'h7777_7777; pstrb = 4'hF;
    psel = 2'b10; penable = 1'b0;
    driveParity(1'b0);
    @(negedge clk);
    penable = 1'b1;
    driveParity(1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    resetModel();
    checkResetOutputs(1);
    checkResetOutputs(0);
    psel = '0; penable = 1'b0;
    driveParity(1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 16'h0018, 1'b0, 32'h0, 4'h0, 1'b0);
    applyStimulus(1, 16'h0018, 1'b1, 32'h1357_9BDF, 4'hF, 1'b0);
    applyStimulus(1, 16'h0018, 1'b0, 32'h0, 4'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
